// File: rtl/nand_avalon_csr.sv
// Avalon-style CSR responder for the NAND controller: decodes DATA/CMD/STATUS
// accesses and hands commands to the NAND command engine over valid/ready.
module nand_avalon_csr #(
    parameter int DATA_W         = 32,
    parameter int NUM_CMDS       = 24,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        address,
    input  logic              pread,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [7:0]        cmd_code,
    output logic [7:0]        cmd_arg,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    input  logic [7:0]        cmd_result,
    output logic              cmd_abort,
    input  logic              nand_rnb
);

    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       CMD_LIMIT = 9'(NUM_CMDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       result_q;
    logic             err;
    logic             tmo;
    logic             rnb_meta;
    logic             rnb_s;
    logic [DATA_W-1:0] rd_value;

    logic wr_en;
    logic rd_en;
    logic cmd_wr;
    logic cmd_legal;
    logic cmd_accept;
    logic cmd_reject;
    logic status_rd;
    logic latch_result;
    logic timeout_hit;
    logic unused_wdata;

    // A simultaneous read and write performs only the write.
    assign wr_en        = (pwrite == 1'b0);
    assign rd_en        = (pread == 1'b0) && !wr_en;
    assign cmd_wr       = wr_en && (address == 2'd1);
    assign cmd_legal    = ({1'b0, writedata[7:0]} < CMD_LIMIT);
    assign cmd_accept   = cmd_wr && (state == S_IDLE) && cmd_legal;
    assign cmd_reject   = cmd_wr && !cmd_accept;
    assign status_rd    = rd_en && (address == 2'd2);
    assign latch_result = cmd_done && ((state == S_EXEC) ||
                                       ((state == S_ISSUE) && cmd_ready));
    assign timeout_hit  = (state == S_EXEC) && !cmd_done && (tmo_cnt == CNT_LAST);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_accept) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    next_state = cmd_done ? S_IDLE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cmd_done || timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rd_value = '0;
        case (address)
            2'd0:    rd_value[7:0] = result_q;
            2'd1:    rd_value[7:0] = cmd_code;
            2'd2:    rd_value[3:0] = {tmo, err, rnb_s, (state != S_IDLE)};
            default: rd_value      = '0;
        endcase
    end

    // Status flags are clear-on-read, but a new error on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata  <= '0;
            cmd_code  <= '0;
            cmd_arg   <= '0;
            cmd_abort <= 1'b0;
            result_q  <= '0;
            err       <= 1'b0;
            tmo       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            cmd_abort <= timeout_hit;
            if (wr_en && (address == 2'd0)) begin
                cmd_arg <= writedata[7:0];
            end
            if (cmd_accept) begin
                cmd_code <= writedata[7:0];
            end
            if (latch_result) begin
                result_q <= cmd_result;
            end
            if ((next_state == S_EXEC) && (state != S_EXEC)) begin
                tmo_cnt <= '0;
            end else if (state == S_EXEC) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (cmd_reject) begin
                err <= 1'b1;
            end else if (status_rd) begin
                err <= 1'b0;
            end
            if (timeout_hit) begin
                tmo <= 1'b1;
            end else if (status_rd) begin
                tmo <= 1'b0;
            end
            if (rd_en) begin
                readdata <= rd_value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnb_meta <= 1'b0;
            rnb_s    <= 1'b0;
        end else begin
            rnb_meta <= nand_rnb;
            rnb_s    <= rnb_meta;
        end
    end

endmodule

// File: tb/tb_nand_avalon_csr.sv
// Directed bench for nand_avalon_csr: a vector table for the register protocol
// plus hand sequences for timeout, asynchronous reset and dual-strobe access.
module tb_nand_avalon_csr;

    localparam int DATA_W = 32;
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CMD  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_RSV  = 2'd3;

    logic              clk;
    logic              rst;
    logic [1:0]        address;
    logic              pread;
    logic              pwrite;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [7:0]        cmd_code;
    logic [7:0]        cmd_arg;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_done;
    logic [7:0]        cmd_result;
    logic              cmd_abort;
    logic              nand_rnb;

    int errors = 0;
    int checks = 0;

    nand_avalon_csr #(
        .DATA_W(DATA_W),
        .NUM_CMDS(24),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .pread(pread),
        .pwrite(pwrite),
        .writedata(writedata),
        .readdata(readdata),
        .cmd_code(cmd_code),
        .cmd_arg(cmd_arg),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_done(cmd_done),
        .cmd_result(cmd_result),
        .cmd_abort(cmd_abort),
        .nand_rnb(nand_rnb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        logic        ready;
        logic        done;
        logic [7:0]  result;
        logic        rnb;
        logic [31:0] exp_rdata;
        logic        exp_valid;
        logic [7:0]  exp_code;
        logic [7:0]  exp_arg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] a, logic rd, logic wr, logic [7:0] wd,
                                logic rdy, logic dn, logic [7:0] res, logic rnb,
                                logic [31:0] er, logic ev, logic [7:0] ec, logic [7:0] ea);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd;
        v.ready = rdy; v.done = dn; v.result = res; v.rnb = rnb;
        v.exp_rdata = er; v.exp_valid = ev; v.exp_code = ec; v.exp_arg = ea;
        return v;
    endfunction

    // rd/wr are active-high here and inverted onto the active-low strobes.
    task automatic applyStimulus(input logic [1:0] a, input logic rd, input logic wr,
                                 input logic [7:0] wd, input logic rdy, input logic dn,
                                 input logic [7:0] res, input logic rnb);
        address    = a;
        pread      = ~rd;
        pwrite     = ~wr;
        writedata  = {24'd0, wd};
        cmd_ready  = rdy;
        cmd_done   = dn;
        cmd_result = res;
        nand_rnb   = rnb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int abort_first;
        int abort_count;

        rst = 1'b1;
        address = 2'd0; pread = 1'b1; pwrite = 1'b1; writedata = '0;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_result = 8'h00; nand_rnb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_readdata", readdata, 32'h0);
        checkOutput("reset_valid", {31'd0, cmd_valid}, 32'h0);
        checkOutput("reset_code", {24'd0, cmd_code}, 32'h0);
        checkOutput("reset_arg", {24'd0, cmd_arg}, 32'h0);
        checkOutput("reset_abort", {31'd0, cmd_abort}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //            addr    rd wr wd     rdy dn res    rnb  rdata  v  code   arg
        vecs.push_back(mk(A_DATA, 0, 1, 8'h5A, 0, 0, 8'h00, 0, 32'h00, 0, 8'h00, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h11, 0, 0, 8'h00, 0, 32'h00, 1, 8'h11, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 0, 32'h01, 1, 8'h11, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 1, 0, 8'h00, 0, 32'h01, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 0, 0, 8'h00, 1, 32'h01, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 0, 1, 8'h3C, 1, 32'h01, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h02, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h3C, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_CMD,  1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h11, 0, 8'h11, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h02, 0, 0, 8'h00, 1, 32'h11, 1, 8'h02, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 1, 0, 8'h00, 1, 32'h11, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h06, 0, 0, 8'h00, 1, 32'h11, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h07, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h03, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 0, 1, 8'h99, 1, 32'h03, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h1E, 0, 0, 8'h00, 1, 32'h03, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 0, 0, 8'h00, 1, 32'h03, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h06, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h02, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 0, 1, 8'h55, 1, 32'h02, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h99, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_RSV,  1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h00, 0, 8'h02, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h03, 0, 0, 8'h00, 1, 32'h00, 1, 8'h03, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 1, 0, 8'h00, 1, 32'h00, 0, 8'h03, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h05, 0, 1, 8'h44, 1, 32'h00, 0, 8'h03, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h06, 0, 8'h03, 8'h5A));
        vecs.push_back(mk(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h44, 0, 8'h03, 8'h5A));
        vecs.push_back(mk(A_CMD,  0, 1, 8'h04, 0, 0, 8'h00, 1, 32'h44, 1, 8'h04, 8'h5A));
        vecs.push_back(mk(A_DATA, 0, 0, 8'h00, 1, 1, 8'h77, 1, 32'h44, 0, 8'h04, 8'h5A));
        vecs.push_back(mk(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h02, 0, 8'h04, 8'h5A));
        vecs.push_back(mk(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1, 32'h77, 0, 8'h04, 8'h5A));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
                          vecs[i].ready, vecs[i].done, vecs[i].result, vecs[i].rnb);
            checkOutput($sformatf("vec%0d_rdata", i), readdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, cmd_valid}, {31'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_code", i), {24'd0, cmd_code}, {24'd0, vecs[i].exp_code});
            checkOutput($sformatf("vec%0d_arg", i), {24'd0, cmd_arg}, {24'd0, vecs[i].exp_arg});
            checkOutput($sformatf("vec%0d_abort", i), {31'd0, cmd_abort}, 32'h0);
        end

        // Timeout: abort must appear once, on the 16th edge after EXEC entry.
        applyStimulus(A_CMD, 0, 1, 8'h08, 0, 0, 8'h00, 1);
        checkOutput("tmo_issue_valid", {31'd0, cmd_valid}, 32'h1);
        applyStimulus(A_DATA, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        checkOutput("tmo_exec_valid", {31'd0, cmd_valid}, 32'h0);
        abort_first = -1;
        abort_count = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(A_DATA, 0, 0, 8'h00, 0, 0, 8'h00, 1);
            if (cmd_abort) begin
                if (abort_first < 0) abort_first = k;
                abort_count++;
            end
        end
        checkOutput("tmo_abort_cycle", abort_first, 32'd16);
        checkOutput("tmo_abort_count", abort_count, 32'd1);
        applyStimulus(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("tmo_status", readdata, 32'h0A);
        applyStimulus(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("tmo_data_kept", readdata, 32'h77);
        applyStimulus(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("tmo_status_cleared", readdata, 32'h02);

        // Asynchronous reset while a command is being offered.
        applyStimulus(A_DATA, 0, 1, 8'h33, 0, 0, 8'h00, 1);
        applyStimulus(A_CMD, 0, 1, 8'h09, 0, 0, 8'h00, 1);
        applyStimulus(A_CMD, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        applyStimulus(A_CMD, 0, 1, 8'h07, 0, 0, 8'h00, 1);
        checkOutput("arst_pre_valid", {31'd0, cmd_valid}, 32'h1);
        checkOutput("arst_pre_rdata", readdata, 32'h09);
        address = A_DATA; pread = 1'b1; pwrite = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'd0, cmd_valid}, 32'h0);
        checkOutput("arst_rdata", readdata, 32'h0);
        checkOutput("arst_code", {24'd0, cmd_code}, 32'h0);
        checkOutput("arst_arg", {24'd0, cmd_arg}, 32'h0);
        #2 rst = 1'b0;
        applyStimulus(A_STAT, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("arst_status", readdata, 32'h00);
        applyStimulus(A_CMD, 0, 1, 8'h0A, 0, 0, 8'h00, 1);
        checkOutput("arst_reissue_valid", {31'd0, cmd_valid}, 32'h1);
        checkOutput("arst_reissue_code", {24'd0, cmd_code}, 32'h0A);
        applyStimulus(A_DATA, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        applyStimulus(A_DATA, 0, 0, 8'h00, 0, 1, 8'h21, 1);
        applyStimulus(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("arst_result", readdata, 32'h21);

        // Read and write strobes together: the write happens, readdata holds.
        applyStimulus(A_CMD, 1, 1, 8'h0D, 0, 0, 8'h00, 1);
        checkOutput("dual_rdata_hold", readdata, 32'h21);
        checkOutput("dual_valid", {31'd0, cmd_valid}, 32'h1);
        checkOutput("dual_code", {24'd0, cmd_code}, 32'h0D);
        applyStimulus(A_DATA, 0, 0, 8'h00, 1, 1, 8'h10, 1);
        checkOutput("dual_done_valid", {31'd0, cmd_valid}, 32'h0);
        applyStimulus(A_DATA, 1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkOutput("dual_result", readdata, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
